// File: rtl/normalizer_seq.sv
// ---------------------------------------------------------------------------
// normalizer_seq
//
// Purpose:
//   Multi-cycle normalizer, the inverse of the datapath barrel shifter.
//   It finds the left shift that left-justifies an operand. It returns the
//   normalized word and that shift count, so the count can drive the
//   shifter's sa input or an FP exponent adjust. It runs a binary search
//   with one power-of-two step per clock: SAW steps, largest step first.
//
// Handshake (valid/ready style):
//   start is the request. It is accepted on an edge where the block is not
//   busy (IDLE or DONE), and d is sampled on that same edge only. busy is
//   high for exactly SAW cycles after acceptance. done is a one-cycle pulse
//   in the cycle after the last step. norm/cnt/zero change only on the
//   completing edge and hold otherwise. A start seen during the done cycle
//   is accepted immediately, which allows back-to-back operations.
//
// Ports:
//   clk    in   rising-edge clock
//   clrn   in   asynchronous active-low reset
//   start  in   request, ignored while busy
//   d      in   operand [WIDTH-1:0]
//   arith  in   signed-normalization select (only with NORM_SIGNED_EN)
//   busy   out  search in progress
//   done   out  one-cycle completion pulse
//   norm   out  normalized word [WIDTH-1:0], held
//   cnt    out  shift amount 0..WIDTH [SAW:0], held
//   zero   out  operand was all zeros, held
//
// Configuration:
//   NORM_SIGNED_EN - when defined, adds the arith input and signed
//   normalization, which counts redundant sign bits. When undefined, the
//   block is unsigned only.
// ---------------------------------------------------------------------------
module normalizer_seq #(
    parameter int WIDTH = 32,
    parameter int SAW   = 5
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [WIDTH-1:0] d,
`ifdef NORM_SIGNED_EN
    input  logic             arith,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] norm,
    output logic [SAW:0]     cnt,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [SAW-1:0] K_INIT    = SAW'(SAW - 1);
    localparam logic [SAW:0]   STEP_ONE  = (SAW+1)'(1);
    localparam logic [SAW:0]   CNT_ZERO  = (SAW+1)'(WIDTH);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_w;
    logic [SAW:0]     r_pc;
    logic [SAW-1:0]   r_k;
    logic             r_zop;
    logic [WIDTH-1:0] r_norm;
    logic [SAW:0]     r_cnt;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic [SAW:0]     w_step;
    logic [WIDTH-1:0] w_mask_u;
    logic             w_take;
    logic [WIDTH-1:0] w_w_nxt;
    logic [SAW:0]     w_pc_nxt;

`ifdef NORM_SIGNED_EN
    logic             r_arith;
    logic [WIDTH-1:0] w_mask_s;
    logic [WIDTH-1:0] w_top_s;
`endif

    // Step size for the current search position is 2^k.
    assign w_step   = STEP_ONE << r_k;
    // Mask that selects the top 2^k bits of the working word.
    assign w_mask_u = ~(ALL_ONES >> w_step);

`ifdef NORM_SIGNED_EN
    // In signed mode the top 2^k+1 bits must all match. That way the bit
    // that remains at the top after the shift is still a sign bit.
    assign w_mask_s = ~(ALL_ONES >> (w_step + STEP_ONE));
    assign w_top_s  = r_w & w_mask_s;
    assign w_take   = r_arith ? ((w_top_s == '0) || (w_top_s == w_mask_s))
                              : ((r_w & w_mask_u) == '0);
`else
    assign w_take   = ((r_w & w_mask_u) == '0);
`endif

    assign w_w_nxt  = w_take ? (r_w << w_step) : r_w;
    assign w_pc_nxt = w_take ? (r_pc + w_step) : r_pc;

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_state == RUN) && (r_k == '0);

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (r_k == '0) w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = start ? RUN : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= IDLE;
            r_w     <= '0;
            r_pc    <= '0;
            r_k     <= '0;
            r_zop   <= 1'b0;
            r_norm  <= '0;
            r_cnt   <= '0;
            r_zero  <= 1'b0;
`ifdef NORM_SIGNED_EN
            r_arith <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_w   <= d;
                r_pc  <= '0;
                r_k   <= K_INIT;
                r_zop <= (d == '0);
`ifdef NORM_SIGNED_EN
                r_arith <= arith;
`endif
            end else if (r_state == RUN) begin
                r_w  <= w_w_nxt;
                r_pc <= w_pc_nxt;
                r_k  <= r_k - 1'b1;
            end
            // The completing edge publishes the post-step word and count.
            // A zero operand is reported as WIDTH rather than the search
            // result, because no shift can left-justify it.
            if (w_last) begin
                if (r_zop) begin
                    r_norm <= '0;
                    r_cnt  <= CNT_ZERO;
                    r_zero <= 1'b1;
                end else begin
                    r_norm <= w_w_nxt;
                    r_cnt  <= w_pc_nxt;
                    r_zero <= 1'b0;
                end
            end
        end
    end

    assign norm = r_norm;
    assign cnt  = r_cnt;
    assign zero = r_zero;

endmodule

// File: tb/tb_normalizer_seq.sv
// ---------------------------------------------------------------------------
// tb_normalizer_seq
//
// Self-checking bench for normalizer_seq. Operations use directed operands
// and random operands. Expected results come from a leading-bit counting
// model. Directed operands use their known results.
// ---------------------------------------------------------------------------
module tb_normalizer_seq;

    localparam int WIDTH = 32;
    localparam int SAW   = 5;

    logic             clk;
    logic             clrn;
    logic             start;
    logic [WIDTH-1:0] d;
    logic             arith_v;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] norm;
    logic [SAW:0]     cnt;
    logic             zero;

    normalizer_seq #(.WIDTH(WIDTH), .SAW(SAW)) dut (
        .clk   (clk),
        .clrn  (clrn),
        .start (start),
        .d     (d),
`ifdef NORM_SIGNED_EN
        .arith (arith_v),
`endif
        .busy  (busy),
        .done  (done),
        .norm  (norm),
        .cnt   (cnt),
        .zero  (zero)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [WIDTH-1:0] exp_q[$];
    logic [SAW:0]     exp_cnt_q[$];
    logic             exp_zero_q[$];
    logic [WIDTH-1:0] last_norm;
    logic [SAW:0]     last_cnt;
    logic             last_zero;
    int               n_pass;
    int               n_total;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference model. It counts how many leading bits can be shifted out
    // while the value stays unchanged in magnitude (unsigned) or in sign
    // (signed).
    task automatic ref_model(input logic [WIDTH-1:0] dv, input bit ar,
                             output logic [WIDTH-1:0] n, output logic [SAW:0] c,
                             output logic z);
        int lead;
        if (dv == '0) begin
            n = '0; c = (SAW+1)'(WIDTH); z = 1'b1;
        end else begin
            lead = 0;
            if (ar) begin
                for (int i = WIDTH - 2; i >= 0; i--) begin
                    if (dv[i] != dv[WIDTH-1]) break;
                    lead++;
                end
            end else begin
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    if (dv[i]) break;
                    lead++;
                end
            end
            n = dv << lead; c = (SAW+1)'(lead); z = 1'b0;
        end
    endtask

    // ---------------- driver ----------------
    // Entered at a negedge with the DUT in IDLE or DONE. Returns at the
    // negedge of the done cycle, with start low.
    task automatic run_op(input logic [WIDTH-1:0] dv, input bit ar, input bit hammer,
                          input bit use_exp, input logic [WIDTH-1:0] e_norm,
                          input logic [SAW:0] e_cnt, input logic e_zero);
        logic [WIDTH-1:0] m_n;
        logic [SAW:0]     m_c;
        logic             m_z;
        ref_model(dv, ar, m_n, m_c, m_z);
        if (use_exp) begin
            m_n = e_norm; m_c = e_cnt; m_z = e_zero;
        end
        exp_q.push_back(m_n);
        exp_cnt_q.push_back(m_c);
        exp_zero_q.push_back(m_z);
        start = 1'b1; d = dv; arith_v = ar;
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < SAW; i++) begin
            chk("busy_run", {63'd0, busy}, 64'd1);
            chk("done_run", {63'd0, done}, 64'd0);
            chk("norm_hold", {32'd0, norm}, {32'd0, last_norm});
            chk("cnt_hold", {58'd0, cnt}, {58'd0, last_cnt});
            if (hammer) begin
                start = 1'b1; d = $urandom; arith_v = ~ar;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); @(negedge clk);
        end
        start = 1'b0;
        chk("done_pulse", {63'd0, done}, 64'd1);
        chk("busy_done", {63'd0, busy}, 64'd0);
        last_norm = exp_q.pop_front();
        last_cnt  = exp_cnt_q.pop_front();
        last_zero = exp_zero_q.pop_front();
        chk("norm", {32'd0, norm}, {32'd0, last_norm});
        chk("cnt", {58'd0, cnt}, {58'd0, last_cnt});
        chk("zero", {63'd0, zero}, {63'd0, last_zero});
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); @(negedge clk);
            chk("idle_done", {63'd0, done}, 64'd0);
            chk("idle_busy", {63'd0, busy}, 64'd0);
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_norm"}, {32'd0, norm}, 64'd0);
        chk({tag, "_cnt"}, {58'd0, cnt}, 64'd0);
        chk({tag, "_zero"}, {63'd0, zero}, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [WIDTH-1:0] rv;
        bit               ra;
        n_pass = 0; n_total = 0;
        last_norm = '0; last_cnt = '0; last_zero = 1'b0;
        clrn = 1'b0; start = 1'b0; d = '0; arith_v = 1'b0;
        @(negedge clk); @(negedge clk);
        check_cleared("reset");
        clrn = 1'b1;
        @(negedge clk);
        check_cleared("post_reset");

        // Directed operands, issued back to back through the DONE cycle.
        run_op(32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 6'd31, 1'b0);
        run_op(32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 6'd0, 1'b0);
        run_op(32'h0000_F000, 1'b0, 1'b0, 1'b1, 32'hF000_0000, 6'd16, 1'b0);
        run_op(32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 6'd32, 1'b1);
        run_op(32'h0040_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 6'd9, 1'b0);
        idle_cycles(2);

        // start and d are hammered during RUN. Only the first operand counts.
        run_op(32'h0000_0100, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 6'd23, 1'b0);
        idle_cycles(3);

        // start is held high continuously, so every done cycle restarts.
        start = 1'b1; d = 32'h0001_0000; arith_v = 1'b0;
        @(posedge clk); @(negedge clk);
        for (int op = 0; op < 3; op++) begin
            for (int i = 0; i < SAW; i++) begin
                chk("b2b_busy", {63'd0, busy}, 64'd1);
                chk("b2b_done_low", {63'd0, done}, 64'd0);
                @(posedge clk); @(negedge clk);
            end
            chk("b2b_done", {63'd0, done}, 64'd1);
            chk("b2b_cnt", {58'd0, cnt}, 64'd15);
            chk("b2b_norm", {32'd0, norm}, 64'h8000_0000);
            if (op < 2) begin
                @(posedge clk); @(negedge clk);
            end
        end
        start = 1'b0;
        last_norm = 32'h8000_0000; last_cnt = 6'd15; last_zero = 1'b0;
        idle_cycles(2);

        // Reset during the third RUN cycle abandons the search.
        start = 1'b1; d = 32'h0000_0003; arith_v = 1'b0;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        clrn = 1'b0;
        #1;
        check_cleared("mid_reset");
        @(negedge clk);
        clrn = 1'b1;
        last_norm = '0; last_cnt = '0; last_zero = 1'b0;
        idle_cycles(8);
        chk("after_rst_norm", {32'd0, norm}, 64'd0);
        run_op(32'h0000_0003, 1'b0, 1'b0, 1'b1, 32'hC000_0000, 6'd30, 1'b0);
        idle_cycles(1);

`ifdef NORM_SIGNED_EN
        run_op(32'hFFFF_FF00, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 6'd23, 1'b0);
        run_op(32'h0000_0003, 1'b1, 1'b0, 1'b1, 32'h6000_0000, 6'd29, 1'b0);
        run_op(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 6'd31, 1'b0);
        run_op(32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 6'd32, 1'b1);
        idle_cycles(1);
`endif

        // Random operands that span the whole range of counts.
        for (int t = 0; t < 40; t++) begin
            rv = $urandom;
            rv = rv >> $urandom_range(0, WIDTH - 1);
            if ($urandom_range(0, 15) == 0) rv = '0;
`ifdef NORM_SIGNED_EN
            ra = bit'($urandom_range(0, 1));
            if (ra && $urandom_range(0, 1) == 1) rv = ~rv;
`else
            ra = 1'b0;
`endif
            run_op(rv, ra, bit'($urandom_range(0, 1)), 1'b0, '0, '0, 1'b0);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
